// File: rtl/freq_div_pkg.sv
// Shared types and the configuration legality rule for the freq_div_multi divider bank.
package freq_div_pkg;

    localparam int CNT_W_DEF = 16;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] div;
        logic [CNT_W_DEF-1:0] high;
    } cfg_t;

    // 32-bit arguments let any counter width up to 32 share the same rule.
    function automatic logic cfg_legal(input logic [31:0] div, input logic [31:0] high);
        return (div >= 32'd2) && (high >= 32'd1) && (high < div);
    endfunction

endpackage

// File: rtl/freq_div_channel.sv
// One divider channel: period counter, active and shadow ratio registers, registered outputs.
module freq_div_channel
    import freq_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_DIV  = 4,
    parameter int DEF_HIGH = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             syncIn,
    input  logic             wrEn,
    input  logic [CNT_W-1:0] wrDiv,
    input  logic [CNT_W-1:0] wrHigh,
    output logic             clkOut,
    output logic             tick,
    output logic             pend
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic [CNT_W-1:0] cntInc;
    logic [CNT_W-1:0] activeDiv;
    logic [CNT_W-1:0] activeHigh;
    logic [CNT_W-1:0] shadowDiv;
    logic [CNT_W-1:0] shadowHigh;
    logic             running;
    logic             restart;
    logic             applyNow;
    logic             clkNext;
    logic             tickNext;

    assign cntInc = cnt + CNT_W'(1);

    // A new period starts on wrap, on sync, or on the first enabled edge after idle.
    // The high phase is never empty, so a period always opens with clkOut high.
    always_comb begin
        applyNow = 1'b0;
        cntNext  = '0;
        clkNext  = 1'b0;
        tickNext = 1'b0;
        restart  = syncIn || !running || (cnt == activeDiv - CNT_W'(1));
        if (!enable) begin
            applyNow = pend;
        end else if (restart) begin
            applyNow = pend;
            clkNext  = 1'b1;
            tickNext = 1'b1;
        end else begin
            cntNext = cntInc;
            clkNext = (cntInc < activeHigh);
        end
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            clkOut     <= 1'b0;
            tick       <= 1'b0;
            running    <= 1'b0;
            activeDiv  <= CNT_W'(DEF_DIV);
            activeHigh <= CNT_W'(DEF_HIGH);
            shadowDiv  <= '0;
            shadowHigh <= '0;
            pend       <= 1'b0;
        end else begin
            cnt     <= cntNext;
            clkOut  <= clkNext;
            tick    <= tickNext;
            running <= enable;
            if (applyNow) begin
                activeDiv  <= shadowDiv;
                activeHigh <= shadowHigh;
            end
            // A write coinciding with an apply refills the shadow, so pend stays set.
            if (wrEn) begin
                shadowDiv  <= wrDiv;
                shadowHigh <= wrHigh;
                pend       <= 1'b1;
            end else if (applyNow) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/freq_div_multi.sv
// N-channel programmable frequency divider: config decode, error pulse and sync fan-out.
module freq_div_multi
    import freq_div_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_DIV  = 4,
    parameter int DEF_HIGH = 2,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_in,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pend
);

    logic cfgOk;

    assign cfgOk = cfg_legal(32'(cfg_div), 32'(cfg_high)) && (int'(cfg_ch) < NUM_CH);

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_wr && !cfgOk;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : gCh
        freq_div_channel #(
            .CNT_W    (CNT_W),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) uCh (
            .clock_in (clock_in),
            .reset    (reset),
            .enable   (ch_en[i]),
            .syncIn   (sync_in),
            .wrEn     (cfg_wr && cfgOk && (cfg_ch == CH_W'(i))),
            .wrDiv    (cfg_div),
            .wrHigh   (cfg_high),
            .clkOut   (clk_out[i]),
            .tick     (tick[i]),
            .pend     (cfg_pend[i])
        );
    end

endmodule

// File: tb/tb_freq_div_multi.sv
// Directed bench for freq_div_multi: vector table for steady-state and config checks,
// hand sequences for sync, idle apply and asynchronous reset.
`timescale 1ns/1ps
module tb_freq_div_multi;
    import freq_div_pkg::*;

    logic        clock_in = 1'b0;
    logic        reset;
    logic [2:0]  ch_en;
    logic        sync_in;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [15:0] cfg_high;
    logic        cfg_err;
    logic [2:0]  clk_out;
    logic [2:0]  tick;
    logic [2:0]  cfg_pend;

    int checks = 0;
    int failures = 0;

    freq_div_multi #(
        .NUM_CH   (3),
        .CNT_W    (16),
        .DEF_DIV  (4),
        .DEF_HIGH (2)
    ) dut (
        .clock_in (clock_in),
        .reset    (reset),
        .ch_en    (ch_en),
        .sync_in  (sync_in),
        .cfg_wr   (cfg_wr),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .cfg_err  (cfg_err),
        .clk_out  (clk_out),
        .tick     (tick),
        .cfg_pend (cfg_pend)
    );

    always #5 clock_in = ~clock_in;

    typedef struct packed {
        logic [2:0] en;
        logic       wr;
        logic [1:0] ch;
        cfg_t       cfg;
        logic [2:0] eClk;
        logic [2:0] eTick;
        logic [2:0] ePend;
        logic       eErr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] en, input logic wr, input logic [1:0] ch,
                                input logic [15:0] div, input logic [15:0] high,
                                input logic [2:0] eClk, input logic [2:0] eTick,
                                input logic [2:0] ePend, input logic eErr);
        vec_t v;
        v.en = en; v.wr = wr; v.ch = ch;
        v.cfg.div = div; v.cfg.high = high;
        v.eClk = eClk; v.eTick = eTick; v.ePend = ePend; v.eErr = eErr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic [2:0] en, input logic sync, input logic wr,
                         input logic [1:0] ch, input logic [15:0] div, input logic [15:0] high);
        ch_en = en; sync_in = sync; cfg_wr = wr; cfg_ch = ch; cfg_div = div; cfg_high = high;
    endtask

    task automatic stepEdge();
        @(posedge clock_in);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int hi2, tk0, tk1, tk2, idleAct;
        logic [6:0] expClk1;
        logic [6:0] expTick1;
        logic [7:0] expClkR;
        logic [7:0] expTickR;

        // {en, wr, ch, div, high} -> {clk_out, tick, cfg_pend, cfg_err} after the edge
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 1, 1, 10, 5, 3'b000, 3'b000, 3'b010, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b010, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b111, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b111, 3'b101, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b101, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b101, 3'b101, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b101, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b010, 3'b010, 3'b000, 0));
        vecs.push_back(mk(3'b111, 1, 0, 1, 0, 3'b010, 3'b000, 3'b000, 1));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b111, 3'b101, 3'b000, 0));
        vecs.push_back(mk(3'b111, 1, 0, 8, 0, 3'b111, 3'b000, 3'b000, 1));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 1, 2, 8, 8, 3'b000, 3'b000, 3'b000, 1));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b101, 3'b101, 3'b000, 0));
        vecs.push_back(mk(3'b111, 1, 3, 8, 4, 3'b101, 3'b000, 3'b000, 1));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
        vecs.push_back(mk(3'b111, 0, 0, 0, 0, 3'b111, 3'b111, 3'b000, 0));

        reset = 1'b0;
        drive(3'b000, 0, 0, 0, 0, 0);
        #3;
        check("reset_state", 32'({clk_out, tick, cfg_pend, cfg_err}), 32'd0);
        ch_en = 3'b111;
        stepEdge();
        stepEdge();
        check("reset_hold", 32'({clk_out, tick, cfg_pend, cfg_err}), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, 0, vecs[i].wr, vecs[i].ch, vecs[i].cfg.div, vecs[i].cfg.high);
            stepEdge();
            check($sformatf("vec%0d", i), 32'({clk_out, tick, cfg_pend, cfg_err}),
                  32'({vecs[i].eClk, vecs[i].eTick, vecs[i].ePend, vecs[i].eErr}));
        end

        // ch2 to 20/10, let phases drift apart, then sync
        drive(3'b111, 0, 1, 2, 20, 10);
        stepEdge();
        check("ch2_pend_set", 32'(cfg_pend), 32'b100);
        drive(3'b111, 0, 0, 0, 0, 0);
        stepEdge();
        stepEdge();
        stepEdge();
        check("ch2_apply_on_wrap", 32'(cfg_pend), 32'b000);
        for (int i = 0; i < 5; i++) stepEdge();
        check("pre_sync_phase", 32'({clk_out, tick}), 32'({3'b101, 3'b000}));
        sync_in = 1'b1;
        stepEdge();
        check("sync_aligns", 32'({clk_out, tick}), 32'({3'b111, 3'b111}));
        sync_in = 1'b0;
        hi2 = 1; tk0 = 1; tk1 = 1; tk2 = 1;
        for (int k = 1; k < 20; k++) begin
            stepEdge();
            hi2 += int'(clk_out[2]);
            tk0 += int'(tick[0]);
            tk1 += int'(tick[1]);
            tk2 += int'(tick[2]);
        end
        check("ch2_high_count", 32'(hi2), 32'd10);
        check("ch2_tick_count", 32'(tk2), 32'd1);
        check("ch0_tick_count", 32'(tk0), 32'd5);
        check("ch1_tick_count", 32'(tk1), 32'd2);
        stepEdge();
        check("period20_wrap", 32'({clk_out, tick}), 32'({3'b111, 3'b111}));

        // ch1 gets 6/3 pending, then idles for 7 edges
        drive(3'b111, 0, 1, 1, 6, 3);
        stepEdge();
        check("ch1_pend_set", 32'(cfg_pend), 32'b010);
        drive(3'b101, 0, 0, 0, 0, 0);
        idleAct = 0;
        stepEdge();
        check("idle_apply", 32'(cfg_pend), 32'b000);
        idleAct += int'(clk_out[1]) + int'(tick[1]);
        for (int i = 0; i < 6; i++) begin
            stepEdge();
            idleAct += int'(clk_out[1]) + int'(tick[1]);
        end
        check("idle_quiet", 32'(idleAct), 32'd0);
        ch_en = 3'b111;
        expClk1 = 7'b1000111;
        expTick1 = 7'b1000001;
        for (int k = 0; k < 7; k++) begin
            stepEdge();
            check($sformatf("ch1_new_ratio_k%0d", k), 32'({clk_out[1], tick[1]}),
                  32'({expClk1[k], expTick1[k]}));
        end

        // pending config on ch0, then reset mid-period
        drive(3'b111, 0, 1, 0, 8, 3);
        stepEdge();
        check("pre_reset", 32'({clk_out[1], cfg_pend}), 32'({1'b1, 3'b001}));
        drive(3'b111, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 32'({clk_out, tick, cfg_pend, cfg_err}), 32'd0);
        #1;
        reset = 1'b1;
        expClkR = 8'b00110011;
        expTickR = 8'b00010001;
        for (int r = 0; r < 8; r++) begin
            stepEdge();
            check($sformatf("post_reset_r%0d", r), 32'({clk_out, tick, cfg_pend}),
                  32'({{3{expClkR[r]}}, {3{expTickR[r]}}, 3'b000}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
